// File: rtl/etc_pkg.sv
// Shared constants, FSM encodings and helpers for the toll-lane speed reporter.
package etc_pkg;

    localparam logic [7:0]  FRAME_HDR   = 8'hA5;
    localparam int unsigned FRAME_BYTES = 4;

    typedef enum logic [1:0] {FR_IDLE, FR_LOAD, FR_SEND} frame_state_t;
    typedef enum logic [1:0] {BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP} bit_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned sys_freq, input int unsigned baud);
        return sys_freq / baud;
    endfunction

    // Byte idx of the frame: header, speed high, speed low, xor checksum.
    function automatic logic [7:0] frame_byte(input logic [15:0] speed, input logic [1:0] idx);
        case (idx)
            2'd0:    return FRAME_HDR;
            2'd1:    return speed[15:8];
            2'd2:    return speed[7:0];
            default: return speed[15:8] ^ speed[7:0];
        endcase
    endfunction

endpackage

// File: rtl/etc_speed_reporter_if.sv
// Result bus from the lane core plus the reporter's host-facing status.
interface etc_speed_reporter_if #(
    parameter int unsigned WIDTH_SPEED = 14
);
    logic [WIDTH_SPEED:0] done_speed;
    logic                 uart_tx;
    logic                 busy;
    logic                 overspeed;
    logic [7:0]           drop_cnt;

    modport master (output done_speed, input uart_tx, busy, overspeed, drop_cnt);
    modport slave  (input done_speed, output uart_tx, busy, overspeed, drop_cnt);
endinterface

// File: rtl/etc_uart_tx_byte.sv
// 8N1 byte serializer; a start on the last stop-bit cycle chains the next byte with no gap.
module etc_uart_tx_byte
    import etc_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx,
    output logic       last_c
);
    localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    bit_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       sh, sh_nxt;
    logic             tx_nxt;
    logic             bit_end;

    assign bit_end = (cnt == CNT_LAST);
    assign last_c  = (state == BIT_STOP) && bit_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= BIT_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            sh      <= sh_nxt;
            tx      <= tx_nxt;
            busy    <= (state_nxt != BIT_IDLE);
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = bit_end ? '0 : cnt + CNT_W'(1);
        bit_idx_nxt = bit_idx;
        sh_nxt      = sh;
        tx_nxt      = tx;
        case (state)
            BIT_IDLE: begin
                cnt_nxt = '0;
                if (start) begin
                    state_nxt = BIT_START;
                    tx_nxt    = 1'b0;
                    sh_nxt    = data;
                end
            end
            BIT_START: if (bit_end) begin
                state_nxt   = BIT_DATA;
                bit_idx_nxt = '0;
                tx_nxt      = sh[0];
                sh_nxt      = {1'b0, sh[7:1]};
            end
            BIT_DATA: if (bit_end) begin
                if (bit_idx == 3'd7) begin
                    state_nxt = BIT_STOP;
                    tx_nxt    = 1'b1;
                end else begin
                    bit_idx_nxt = bit_idx + 3'd1;
                    tx_nxt      = sh[0];
                    sh_nxt      = {1'b0, sh[7:1]};
                end
            end
            BIT_STOP: if (bit_end) begin
                if (start) begin
                    state_nxt = BIT_START;
                    tx_nxt    = 1'b0;
                    sh_nxt    = data;
                end else begin
                    state_nxt = BIT_IDLE;
                    tx_nxt    = 1'b1;
                end
            end
            default: state_nxt = BIT_IDLE;
        endcase
    end

endmodule

// File: rtl/etc_speed_reporter.sv
// Captures speed results on done rising edges, buffers them and reports each as a 4-byte UART frame.
module etc_speed_reporter
    import etc_pkg::*;
#(
    parameter int unsigned WIDTH_SPEED = 14,
    parameter int unsigned SYS_FREQ    = 10000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SPEED_LIMIT = 60
) (
    input logic                clk,
    input logic                reset_n,
    etc_speed_reporter_if.slave bus
);
    localparam int unsigned CPB = clks_per_bit(SYS_FREQ, BAUD_RATE);
    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW  = AW + 1;

    logic          done_d, capture_c, full_c, push_c, pop_c, start_c;
    logic [15:0]   speed16, rec;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic [1:0]    byte_idx;
    logic [7:0]    byte_data_c;
    logic          byte_busy, byte_last_c, tx;
    logic          busy_q, overspeed_q;
    logic [7:0]    drop_q;
    frame_state_t  state, state_nxt;

    assign speed16   = 16'(bus.done_speed[WIDTH_SPEED-1:0]);
    assign capture_c = bus.done_speed[WIDTH_SPEED] & ~done_d;
    assign full_c    = (level == LW'(FIFO_DEPTH));
    assign push_c    = capture_c & ~full_c;

    assign bus.uart_tx   = tx;
    assign bus.busy      = busy_q;
    assign bus.overspeed = overspeed_q;
    assign bus.drop_cnt  = drop_q;

    // Edge detect, over-speed flag and saturating drop counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_d      <= 1'b0;
            overspeed_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            done_d <= bus.done_speed[WIDTH_SPEED];
            if (capture_c) overspeed_q <= (speed16 > 16'(SPEED_LIMIT));
            if (capture_c && full_c && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= speed16;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            if (push_c && !pop_c)      level <= level + LW'(1);
            else if (!push_c && pop_c) level <= level - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FR_IDLE;
        else          state <= state_nxt;
    end

    // Frame sequencing: LOAD pops and launches the header, each stop-bit end chains the next byte.
    always_comb begin
        state_nxt   = state;
        pop_c       = 1'b0;
        start_c     = 1'b0;
        byte_data_c = frame_byte(rec, byte_idx + 2'd1);
        case (state)
            FR_IDLE: if (level != '0) state_nxt = FR_LOAD;
            FR_LOAD: begin
                pop_c       = 1'b1;
                start_c     = 1'b1;
                byte_data_c = FRAME_HDR;
                state_nxt   = FR_SEND;
            end
            FR_SEND: if (byte_last_c) begin
                if (byte_idx == 2'(FRAME_BYTES - 1)) state_nxt = FR_IDLE;
                else                                 start_c   = 1'b1;
            end
            default: state_nxt = FR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q   <= 1'b0;
            rec      <= '0;
            byte_idx <= '0;
        end else begin
            busy_q <= (state_nxt != FR_IDLE);
            if (state == FR_LOAD) begin
                rec      <= mem[rd_ptr];
                byte_idx <= '0;
            end else if (state == FR_SEND && byte_last_c) begin
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    etc_uart_tx_byte #(.CLKS_PER_BIT(CPB)) u_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start_c),
        .data    (byte_data_c),
        .busy    (byte_busy),
        .tx      (tx),
        .last_c  (byte_last_c)
    );

    a_serializer_active: assert property (@(posedge clk) disable iff (!reset_n)
        (state == FR_SEND) |-> byte_busy);

endmodule

// File: tb/tb_etc_speed_reporter.sv
// Directed bench for etc_speed_reporter: decodes the UART line and checks frames, flags and timing.
module tb_etc_speed_reporter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   busy_total = 0;

    always #5 clk = ~clk;

    etc_speed_reporter_if #(.WIDTH_SPEED(14)) bus ();

    etc_speed_reporter #(
        .WIDTH_SPEED(14), .SYS_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(4), .SPEED_LIMIT(60)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Busy cycle count, sampled as the pre-edge value.
    always @(posedge clk) if (bus.busy === 1'b1) busy_total <= busy_total + 1;

    task automatic send_pulse(input logic [13:0] spd);
        bus.done_speed = {1'b1, spd};
        @(negedge clk);
        bus.done_speed = {1'b0, spd};
    endtask

    // Number of high samples before the line falls (1000 means it never fell).
    task automatic wait_fall(output int n);
        n = 0;
        while (bus.uart_tx !== 1'b0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_low(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.uart_tx !== 1'b1) lows++;
            @(negedge clk);
        end
    endtask

    // Decode 40 bits of 10 cycles each, starting on the first start-bit sample.
    task automatic rx_frame(output logic [31:0] frm, output int errs);
        logic [39:0] bits;
        logic        first;
        errs = 0;
        frm  = '0;
        for (int i = 0; i < 40; i++) begin
            first = bus.uart_tx;
            for (int c = 0; c < 10; c++) begin
                if (bus.uart_tx !== first) errs++;
                @(negedge clk);
            end
            bits[i] = first;
        end
        for (int k = 0; k < 4; k++) begin
            if (bits[k*10] !== 1'b0 || bits[k*10+9] !== 1'b1) errs++;
            for (int j = 0; j < 8; j++) frm[24-8*k+j] = bits[k*10+1+j];
        end
    endtask

    task automatic test_reset();
        int lows;
        int b0;
        reset_n = 1'b0;
        bus.done_speed = '0;
        repeat (3) @(negedge clk);
        n_vec++; if (bus.uart_tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b expected 1", bus.uart_tx); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_vec++; if (bus.overspeed !== 1'b0) begin n_err++; $display("FAIL reset_overspeed: got %b expected 0", bus.overspeed); end
        n_vec++; if (bus.drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop: got %0d expected 0", bus.drop_cnt); end
        reset_n = 1'b1;
        b0 = busy_total;
        count_low(500, lows);
        n_vec++; if (lows !== 0) begin n_err++; $display("FAIL reset_idle_line: got %0d low cycles expected 0", lows); end
        n_vec++; if (busy_total - b0 !== 0) begin n_err++; $display("FAIL reset_idle_busy: got %0d busy cycles expected 0", busy_total - b0); end
    endtask

    task automatic test_single();
        int n, errs, b0;
        logic [31:0] frm;
        b0 = busy_total;
        send_pulse(14'd1234);
        n_vec++; if (bus.overspeed !== 1'b1) begin n_err++; $display("FAIL single_overspeed: got %b expected 1", bus.overspeed); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_n: got %b expected 0", bus.busy); end
        wait_fall(n);
        n_vec++; if (n !== 2) begin n_err++; $display("FAIL single_latency: got %0d expected 2", n); end
        rx_frame(frm, errs);
        n_vec++; if (frm !== 32'hA504D2D6) begin n_err++; $display("FAIL single_frame: got %h expected a504d2d6", frm); end
        n_vec++; if (errs !== 0) begin n_err++; $display("FAIL single_bit_timing: got %0d errors expected 0", errs); end
        repeat (3) @(negedge clk);
        n_vec++; if (busy_total - b0 !== 401) begin n_err++; $display("FAIL single_busy_len: got %0d expected 401", busy_total - b0); end
    endtask

    task automatic test_level_hold();
        int n, errs, lows;
        logic [31:0] frm;
        fork
            begin
                bus.done_speed = {1'b1, 14'd30};
                repeat (50) @(negedge clk);
                bus.done_speed = {1'b0, 14'd30};
            end
            begin
                @(negedge clk);
                wait_fall(n);
                n_vec++; if (n !== 2) begin n_err++; $display("FAIL hold_latency: got %0d expected 2", n); end
                rx_frame(frm, errs);
                n_vec++; if (frm !== 32'hA5001E1E || errs !== 0) begin n_err++; $display("FAIL hold_frame: got %h errs %0d expected a5001e1e errs 0", frm, errs); end
            end
        join
        n_vec++; if (bus.overspeed !== 1'b0) begin n_err++; $display("FAIL hold_overspeed: got %b expected 0", bus.overspeed); end
        count_low(500, lows);
        n_vec++; if (lows !== 0) begin n_err++; $display("FAIL hold_single_frame: got %0d low cycles expected 0", lows); end
    endtask

    task automatic test_overflow();
        int n, errs, lows;
        logic [31:0] frm;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    send_pulse(14'(i));
                    repeat (2) @(negedge clk);
                end
            end
            begin
                @(negedge clk);
                wait_fall(n);
                n_vec++; if (n !== 2) begin n_err++; $display("FAIL ovf_latency: got %0d expected 2", n); end
                for (int k = 1; k <= 5; k++) begin
                    rx_frame(frm, errs);
                    n_vec++;
                    if (frm !== {8'hA5, 8'h00, 8'(k), 8'(k)} || errs !== 0) begin
                        n_err++; $display("FAIL ovf_frame%0d: got %h errs %0d expected a500%02h%02h", k, frm, errs, k, k);
                    end
                    if (k < 5) begin
                        wait_fall(n);
                        n_vec++; if (n !== 2) begin n_err++; $display("FAIL ovf_gap%0d: got %0d expected 2", k, n); end
                    end
                end
            end
        join
        n_vec++; if (bus.drop_cnt !== 8'd1) begin n_err++; $display("FAIL ovf_drop_cnt: got %0d expected 1", bus.drop_cnt); end
        n_vec++; if (bus.overspeed !== 1'b0) begin n_err++; $display("FAIL ovf_overspeed: got %b expected 0", bus.overspeed); end
        count_low(300, lows);
        n_vec++; if (lows !== 0) begin n_err++; $display("FAIL ovf_no_sixth: got %0d low cycles expected 0", lows); end
    endtask

    task automatic test_mid_reset();
        int n, errs, lows;
        logic [31:0] frm;
        send_pulse(14'd100);
        @(negedge clk);
        send_pulse(14'd200);
        wait_fall(n);
        n_vec++; if (n > 2) begin n_err++; $display("FAIL mid_start: got %0d expected <=2", n); end
        n_vec++; if (bus.overspeed !== 1'b1) begin n_err++; $display("FAIL mid_overspeed_pre: got %b expected 1", bus.overspeed); end
        repeat (140) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_vec++; if (bus.uart_tx !== 1'b1) begin n_err++; $display("FAIL mid_tx_immediate: got %b expected 1", bus.uart_tx); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_busy_immediate: got %b expected 0", bus.busy); end
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        n_vec++; if (bus.drop_cnt !== 8'd0 || bus.overspeed !== 1'b0) begin n_err++; $display("FAIL mid_flags_cleared: got drop %0d ovs %b expected 0 0", bus.drop_cnt, bus.overspeed); end
        count_low(500, lows);
        n_vec++; if (lows !== 0) begin n_err++; $display("FAIL mid_fifo_cleared: got %0d low cycles expected 0", lows); end
        send_pulse(14'd61);
        n_vec++; if (bus.overspeed !== 1'b1) begin n_err++; $display("FAIL limit_plus1_overspeed: got %b expected 1", bus.overspeed); end
        wait_fall(n);
        n_vec++; if (n !== 2) begin n_err++; $display("FAIL mid_post_latency: got %0d expected 2", n); end
        rx_frame(frm, errs);
        n_vec++; if (frm !== 32'hA5003D3D || errs !== 0) begin n_err++; $display("FAIL mid_post_frame: got %h errs %0d expected a5003d3d errs 0", frm, errs); end
    endtask

    task automatic test_boundary();
        int n, errs;
        logic [31:0] frm;
        send_pulse(14'd60);
        n_vec++; if (bus.overspeed !== 1'b0) begin n_err++; $display("FAIL limit_eq_overspeed: got %b expected 0", bus.overspeed); end
        wait_fall(n);
        rx_frame(frm, errs);
        n_vec++; if (frm !== 32'hA5003C3C || errs !== 0 || n !== 2) begin n_err++; $display("FAIL limit_eq_frame: got %h errs %0d lat %0d expected a5003c3c 0 2", frm, errs, n); end
        send_pulse(14'd16383);
        n_vec++; if (bus.overspeed !== 1'b1) begin n_err++; $display("FAIL max_overspeed: got %b expected 1", bus.overspeed); end
        wait_fall(n);
        rx_frame(frm, errs);
        n_vec++; if (frm !== 32'hA53FFFC0 || errs !== 0 || n !== 2) begin n_err++; $display("FAIL max_frame: got %h errs %0d lat %0d expected a53fffc0 0 2", frm, errs, n); end
    endtask

    initial begin
        bus.done_speed = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_level_hold();
        test_overflow();
        test_mid_reset();
        test_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
